fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
//  Synchronous controller between UART_RX, the 16-point FFT core and UART_TX.
//  - Collects FFT_SIZE received bytes into the FFT sample inputs.
//  - Starts one FFT cycle and waits for it to complete.
//  - Serialises the FFT_SIZE real outputs back over UART_TX, 2 bytes each, low byte first.
//  - Replaces the asynchronous edge-driven glue around the FFT with one clocked FSM.
// PARAMETERS
//  FFT_SIZE      16     samples per frame; power of 2
//  WORD_SIZE     16     FFT output word width (2*DATA_LENGTH)
//  DATA_LENGTH   8      UART byte width
//  FFT_TIMEOUT   4096   max cycles in WAIT_FFT before abort
//  FRAME_GAP     43400  idle cycles (~100 bit times) after which a partial frame is discarded
// PORTS
//  i_clk          in   1            system clock
//  i_rst          in   1            synchronous, active-low reset
//  i_rx_valid     in   1            1-cycle strobe: i_rx_byte holds a new received byte
//  i_rx_byte      in   DATA_LENGTH  received byte
//  o_smp_wr       out  1            1-cycle write strobe to the FFT sample register
//  o_smp_idx      out  log2(FFT_SIZE)  sample index being written
//  o_smp_data     out  DATA_LENGTH  sample value (registered copy of i_rx_byte)
//  o_fft_start    out  1            1-cycle pulse: start an FFT cycle
//  i_fft_done     in   1            FFT cycle complete (pulse or level; rising edge is used)
//  o_rd_idx       out  log2(FFT_SIZE)  selects the FFT output word presented on i_fft_word
//  i_fft_word     in   WORD_SIZE    real part of selected FFT output (combinational mux outside)
//  o_tx_start     out  1            1-cycle pulse to UART_TX i_start
//  o_tx_byte      out  DATA_LENGTH  byte to transmit; held stable from o_tx_start until i_tx_done
//  i_tx_done      in   1            1-cycle pulse from UART_TX: byte finished
//  o_busy         out  1            high in every state except COLLECT
//  o_overrun      out  1            1-cycle pulse: rx byte dropped (not in COLLECT)
//  o_error        out  1            1-cycle pulse: FFT timeout abort
// BEHAVIOUR
//  Reset (i_rst==0 at posedge):
//  - State = COLLECT; all counters = 0.
//  - All outputs = 0, including o_smp_idx, o_rd_idx and o_tx_byte.
//  - Applies mid-operation in any state and abandons the frame; no further o_tx_start is issued.
//  Outputs: every output is registered.
//  Edge detection: i_fft_done is edge-detected with a register; that register resets to 0.
//  COLLECT
//  - Each i_rx_valid: o_smp_wr=1, o_smp_data=i_rx_byte, o_smp_idx=smp_cnt, one cycle later.
//  - smp_cnt then increments.
//  - Write of index FFT_SIZE-1 -> START; smp_cnt wraps to 0.
//  - Gap counter is cleared by i_rx_valid and counts only while smp_cnt!=0.
//  - Gap counter reaching FRAME_GAP: smp_cnt=0, stay in COLLECT, no error.
//  - i_fft_done and i_tx_done are ignored.
//  START
//  - o_fft_start=1 for exactly one cycle.
//  - Cycle after last o_smp_wr -> WAIT_FFT; timeout counter cleared.
//  WAIT_FFT
//  - i_fft_done rising edge -> SEND with byte_cnt=0.
//  - Timeout counter reaching FFT_TIMEOUT -> o_error pulse, back to COLLECT.
//  SEND (1 cycle)
//  - o_rd_idx = byte_cnt[4:1].
//  - o_tx_byte = byte_cnt[0] ? i_fft_word[15:8] : i_fft_word[7:0], sampled now.
//  - o_tx_start=1 for one cycle -> WAIT_TX.
//  - o_rd_idx is driven one cycle ahead so i_fft_word is settled when sampled.
//  WAIT_TX
//  - On i_tx_done: if byte_cnt==2*FFT_SIZE-1 -> COLLECT.
//  - Otherwise byte_cnt+1 -> SEND.
//  - Back-to-back spacing: i_tx_done -> next o_tx_start = 2 cycles.
//  Overrun: i_rx_valid in any state other than COLLECT is dropped; o_overrun pulses.
//  Simultaneous events
//  - i_rx_valid in the same cycle as the COLLECT transition from WAIT_TX/WAIT_FFT is dropped (overrun).
//  - i_tx_done outside WAIT_TX is ignored.
//  Latency
//  - 16th i_rx_valid -> o_fft_start: 2 cycles.
//  - i_fft_done edge -> first o_tx_start: 2 cycles.
// TESTING
//  1 Reset, then bytes 0x01..0x10 -> 16 o_smp_wr, idx 0..15, data 0x01..0x10; one o_fft_start; o_busy=1.
//  2 i_fft_done with words[k]=0x1200+k -> 32 o_tx_start pulses; tx bytes 0x00,0x12,0x01,0x12,...,0x0F,0x12; then COLLECT, o_busy=0.
//  3 Send 5 bytes, idle FRAME_GAP cycles, send 16 bytes -> o_smp_idx restarts at 0; exactly one o_fft_start.
//  4 No i_fft_done -> o_error pulse at FFT_TIMEOUT cycles; COLLECT; next frame completes normally.
//  5 i_rx_valid during WAIT_TX -> o_overrun=1 for 1 cycle; tx sequence unaffected.
//  6 i_rst=0 after the 7th tx byte -> no further o_tx_start; outputs 0; a new 16-byte frame restarts at byte 0.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - clocked frame sequencer between UART RX, the FFT core and UART TX
module fft_frame_sequencer #(
  parameter int FFT_SIZE    = 16,
  parameter int WORD_SIZE   = 16,
  parameter int DATA_LENGTH = 8,
  parameter int FFT_TIMEOUT = 4096,
  parameter int FRAME_GAP   = 43400
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_rx_valid,
  input  logic [DATA_LENGTH-1:0]      i_rx_byte,
  output logic                        o_smp_wr,
  output logic [$clog2(FFT_SIZE)-1:0] o_smp_idx,
  output logic [DATA_LENGTH-1:0]      o_smp_data,
  output logic                        o_fft_start,
  input  logic                        i_fft_done,
  output logic [$clog2(FFT_SIZE)-1:0] o_rd_idx,
  input  logic [WORD_SIZE-1:0]        i_fft_word,
  output logic                        o_tx_start,
  output logic [DATA_LENGTH-1:0]      o_tx_byte,
  input  logic                        i_tx_done,
  output logic                        o_busy,
  output logic                        o_overrun,
  output logic                        o_error
);

  localparam int IDX_W = $clog2(FFT_SIZE);
  // byte_cnt walks 2*FFT_SIZE bytes: bit 0 picks low/high byte, upper bits pick the word
  localparam int CNT_W = IDX_W + 1;
  localparam int GAP_W = $clog2(FRAME_GAP + 1);
  localparam int TO_W  = $clog2(FFT_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_SMP  = IDX_W'(FFT_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(2 * FFT_SIZE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(FRAME_GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(FFT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    COLLECT  = 3'd0,
    START    = 3'd1,
    WAIT_FFT = 3'd2,
    SEND     = 3'd3,
    WAIT_TX  = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] smp_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             fft_done_q;
  logic             fft_done_rise;
  logic [CNT_W-1:0] byte_nxt;

  assign fft_done_rise = i_fft_done & ~fft_done_q;
  assign byte_nxt      = byte_cnt + 1'b1;

  // Frame FSM: collect samples, kick the FFT, stream results out; all outputs registered here
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= COLLECT;
      smp_cnt     <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      fft_done_q  <= 1'b0;
      o_smp_wr    <= 1'b0;
      o_smp_idx   <= '0;
      o_smp_data  <= '0;
      o_fft_start <= 1'b0;
      o_rd_idx    <= '0;
      o_tx_start  <= 1'b0;
      o_tx_byte   <= '0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_smp_wr    <= 1'b0;
      o_fft_start <= 1'b0;
      o_tx_start  <= 1'b0;
      o_overrun   <= 1'b0;
      o_error     <= 1'b0;
      fft_done_q  <= i_fft_done;

      // Bytes arriving outside COLLECT have nowhere to go
      if (i_rx_valid && (state != COLLECT)) begin
        o_overrun <= 1'b1;
      end

      case (state)
        COLLECT: begin
          if (i_rx_valid) begin
            o_smp_wr   <= 1'b1;
            o_smp_data <= i_rx_byte;
            o_smp_idx  <= smp_cnt;
            gap_cnt    <= '0;
            if (smp_cnt == LAST_SMP) begin
              smp_cnt <= '0;
              o_busy  <= 1'b1;
              state   <= START;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end else if (smp_cnt != '0) begin
            // A long silence mid-frame means the sender gave up; resync on the next byte
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              smp_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        START: begin
          o_fft_start <= 1'b1;
          to_cnt      <= '0;
          state       <= WAIT_FFT;
        end

        WAIT_FFT: begin
          if (fft_done_rise) begin
            byte_cnt <= '0;
            // Select word 0 now so the external mux has settled when SEND samples it
            o_rd_idx <= '0;
            state    <= SEND;
          end else if (to_cnt == TO_LAST) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            state   <= COLLECT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        SEND: begin
          o_tx_byte  <= byte_cnt[0] ? i_fft_word[DATA_LENGTH +: DATA_LENGTH]
                                    : i_fft_word[0 +: DATA_LENGTH];
          o_tx_start <= 1'b1;
          state      <= WAIT_TX;
        end

        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_cnt == LAST_BYTE) begin
              o_busy <= 1'b0;
              state  <= COLLECT;
            end else begin
              byte_cnt <= byte_nxt;
              o_rd_idx <= byte_nxt[CNT_W-1:1];
              state    <= SEND;
            end
          end
        end

        default: begin
          o_busy <= 1'b0;
          state  <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - randomized self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

  localparam int FFT_SIZE    = 16;
  localparam int WORD_SIZE   = 16;
  localparam int DATA_LENGTH = 8;
  localparam int FFT_TIMEOUT = 4096;
  localparam int FRAME_GAP   = 43400;
  localparam int IDX_W       = $clog2(FFT_SIZE);
  localparam int NBYTES      = 2 * FFT_SIZE;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   rx_valid;
  logic [DATA_LENGTH-1:0] rx_byte;
  logic                   smp_wr;
  logic [IDX_W-1:0]       smp_idx;
  logic [DATA_LENGTH-1:0] smp_data;
  logic                   fft_start;
  logic                   fft_done;
  logic [IDX_W-1:0]       rd_idx;
  logic [WORD_SIZE-1:0]   fft_word;
  logic                   tx_start;
  logic [DATA_LENGTH-1:0] tx_byte;
  logic                   tx_done;
  logic                   busy;
  logic                   overrun;
  logic                   error;

  logic [WORD_SIZE-1:0]   fft_words [FFT_SIZE];
  logic [DATA_LENGTH-1:0] frame     [FFT_SIZE];

  assign fft_word = fft_words[rd_idx];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_sequencer #(
    .FFT_SIZE(FFT_SIZE), .WORD_SIZE(WORD_SIZE), .DATA_LENGTH(DATA_LENGTH),
    .FFT_TIMEOUT(FFT_TIMEOUT), .FRAME_GAP(FRAME_GAP)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_smp_wr(smp_wr), .o_smp_idx(smp_idx), .o_smp_data(smp_data),
    .o_fft_start(fft_start), .i_fft_done(fft_done), .o_rd_idx(rd_idx),
    .i_fft_word(fft_word), .o_tx_start(tx_start), .o_tx_byte(tx_byte),
    .i_tx_done(tx_done), .o_busy(busy), .o_overrun(overrun), .o_error(error)
  );

  int checks   = 0;
  int failures = 0;

  // Observation log, filled on the falling edge
  logic [IDX_W-1:0]       smp_idx_q  [$];
  logic [DATA_LENGTH-1:0] smp_data_q [$];
  logic [DATA_LENGTH-1:0] tx_q       [$];
  int                     tx_cyc_q   [$];
  int fft_start_n = 0, fft_start_cyc = 0;
  int overrun_n = 0, overrun_cyc = 0;
  int error_n = 0, error_cyc = 0;

  always @(negedge clk) begin
    if (smp_wr) begin
      smp_idx_q.push_back(smp_idx);
      smp_data_q.push_back(smp_data);
    end
    if (fft_start) begin
      fft_start_n++;
      fft_start_cyc = cyc;
    end
    if (tx_start) begin
      tx_q.push_back(tx_byte);
      tx_cyc_q.push_back(cyc);
    end
    if (overrun) begin
      overrun_n++;
      overrun_cyc = cyc;
    end
    if (error) begin
      error_n++;
      error_cyc = cyc;
    end
  end

  // UART TX model: random busy time, checks byte hold and start-to-start spacing
  int tx_frame_base = 0;
  int tx_stop_after = 1000000;
  int hold_err      = 0;
  int spacing_err   = 0;
  bit resp_got;
  logic [DATA_LENGTH-1:0] resp_cap;
  int resp_n, resp_pos;

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_got = tx_start;
      while (resp_got) begin
        resp_cap = tx_byte;
        resp_n   = int'($urandom_range(1, 4));
        repeat (resp_n) begin
          @(negedge clk);
          if (rst_n && (tx_start || tx_byte !== resp_cap)) hold_err++;
        end
        resp_pos = tx_q.size() - tx_frame_base;
        if (resp_pos >= tx_stop_after || !rst_n) begin
          resp_got = 1'b0;
        end else begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
          if (resp_pos % NBYTES != 0) begin
            @(negedge clk);
            resp_got = tx_start;
            if (!resp_got) spacing_err++;
          end else begin
            resp_got = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    fft_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_byte(input logic [DATA_LENGTH-1:0] b, output int drv_cyc);
    rx_valid = 1'b1;
    rx_byte  = b;
    drv_cyc  = cyc;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap, output int last_cyc);
    int c;
    for (int i = 0; i < FFT_SIZE; i++) begin
      send_byte(frame[i], c);
      if (i < FFT_SIZE - 1) repeat ($urandom_range(0, max_gap)) step();
    end
    last_cyc = c;
  endtask

  function automatic logic [DATA_LENGTH-1:0] model_tx(input int j);
    logic [WORD_SIZE-1:0] w;
    w = fft_words[j / 2];
    return (j % 2 == 1) ? DATA_LENGTH'(w / 256) : DATA_LENGTH'(w % 256);
  endfunction

  // One complete frame: collect, FFT, 32 transmitted bytes, back to idle
  task automatic frame_roundtrip(input string tag, input int max_gap, input bit extra_rx,
                                 input int inject_at);
    int s_base, t_base, f_base, o_base, e_base, h_base, sp_base;
    int c, xc, fd_cyc, inj_cyc, n_got, exp_ovr;
    bit injected;
    s_base = smp_idx_q.size();
    t_base = tx_q.size();
    tx_frame_base = t_base;
    f_base = fft_start_n; o_base = overrun_n; e_base = error_n;
    h_base = hold_err; sp_base = spacing_err;
    injected = 1'b0; inj_cyc = 0;
    send_frame(max_gap, c);
    if (extra_rx) send_byte(8'h5A, xc);
    repeat (3) step();

    n_got = smp_idx_q.size() - s_base;
    checks++;
    if (n_got !== FFT_SIZE) begin
      failures++; $display("FAIL %s smp_count got=%0d exp=%0d", tag, n_got, FFT_SIZE);
    end
    for (int i = 0; i < FFT_SIZE && i < n_got; i++) begin
      checks++;
      if (smp_idx_q[s_base+i] !== IDX_W'(i) || smp_data_q[s_base+i] !== frame[i]) begin
        failures++;
        $display("FAIL %s smp[%0d] got idx=%0d data=%02h exp idx=%0d data=%02h", tag, i,
                 smp_idx_q[s_base+i], smp_data_q[s_base+i], i, frame[i]);
      end
    end
    checks++;
    if (fft_start_n - f_base !== 1) begin
      failures++; $display("FAIL %s fft_start_count got=%0d exp=1", tag, fft_start_n - f_base);
    end
    checks++;
    if (fft_start_cyc - c !== 2) begin
      failures++; $display("FAIL %s fft_start_latency got=%0d exp=2", tag, fft_start_cyc - c);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_wait_fft got=%b exp=1", tag, busy);
    end

    fft_done = 1'b1;
    fd_cyc   = cyc;
    repeat ($urandom_range(1, 3)) step();
    fft_done = 1'b0;
    for (int k = 0; k < NBYTES * 10 + 50 && tx_q.size() - t_base < NBYTES; k++) begin
      if (inject_at >= 0 && !injected && tx_q.size() - t_base >= inject_at) begin
        send_byte(8'hC3, inj_cyc);
        injected = 1'b1;
      end else begin
        step();
      end
    end
    repeat (12) step();

    n_got = tx_q.size() - t_base;
    checks++;
    if (n_got !== NBYTES) begin
      failures++; $display("FAIL %s tx_count got=%0d exp=%0d", tag, n_got, NBYTES);
    end
    for (int j = 0; j < NBYTES && j < n_got; j++) begin
      checks++;
      if (tx_q[t_base+j] !== model_tx(j)) begin
        failures++;
        $display("FAIL %s tx_byte[%0d] got=%02h exp=%02h", tag, j, tx_q[t_base+j], model_tx(j));
      end
    end
    if (n_got > 0) begin
      checks++;
      if (tx_cyc_q[t_base] - fd_cyc !== 2) begin
        failures++; $display("FAIL %s first_tx_latency got=%0d exp=2", tag, tx_cyc_q[t_base] - fd_cyc);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL %s busy_after got=%b exp=0", tag, busy);
    end
    checks++;
    if (hold_err !== h_base || spacing_err !== sp_base) begin
      failures++;
      $display("FAIL %s tx_handshake hold_err=%0d spacing_err=%0d exp=0,0", tag,
               hold_err - h_base, spacing_err - sp_base);
    end
    exp_ovr = (extra_rx ? 1 : 0) + (inject_at >= 0 ? 1 : 0);
    checks++;
    if (overrun_n - o_base !== exp_ovr) begin
      failures++; $display("FAIL %s overrun_count got=%0d exp=%0d", tag, overrun_n - o_base, exp_ovr);
    end
    if (inject_at >= 0) begin
      checks++;
      if (overrun_cyc - inj_cyc !== 1) begin
        failures++; $display("FAIL %s overrun_latency got=%0d exp=1", tag, overrun_cyc - inj_cyc);
      end
    end
    checks++;
    if (smp_idx_q.size() - s_base !== FFT_SIZE || error_n !== e_base) begin
      failures++;
      $display("FAIL %s stray_events smp=%0d err=%0d exp=%0d,0", tag, smp_idx_q.size() - s_base,
               error_n - e_base, FFT_SIZE);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_byte  = DATA_LENGTH'($urandom);
    fft_done = 1'b1;
    repeat (3) step();
    checks++;
    if ({smp_wr, smp_idx, smp_data, fft_start, rd_idx, tx_start, tx_byte, overrun, error} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got wr=%b idx=%0d data=%02h fs=%b rd=%0d ts=%b tb=%02h ov=%b er=%b exp=0",
               smp_wr, smp_idx, smp_data, fft_start, rd_idx, tx_start, tx_byte, overrun, error);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rx_valid = 1'b0;
    fft_done = 1'b0;
    rst_n    = 1'b1;
    repeat (2) step();
    checks++;
    if ({smp_wr, fft_start, tx_start, busy, overrun, error} !== '0) begin
      failures++; $display("FAIL reset_idle got=%b exp=0", {smp_wr, fft_start, tx_start, busy, overrun, error});
    end
  endtask

  task automatic test_collect_send();
    for (int i = 0; i < FFT_SIZE; i++) begin
      frame[i]     = DATA_LENGTH'(i + 1);
      fft_words[i] = WORD_SIZE'(16'h1200 + i);
    end
    frame_roundtrip("collect_send", 0, 1'b0, -1);
  endtask

  task automatic test_gap();
    logic [DATA_LENGTH-1:0] pre [5];
    int s_base, f_base, c, n_got;
    s_base = smp_idx_q.size();
    f_base = fft_start_n;
    for (int i = 0; i < 5; i++) begin
      pre[i] = DATA_LENGTH'($urandom);
      send_byte(pre[i], c);
    end
    repeat (FRAME_GAP) step();
    for (int i = 0; i < FFT_SIZE; i++) frame[i] = DATA_LENGTH'($urandom);
    send_frame(0, c);
    repeat (4) step();
    n_got = smp_idx_q.size() - s_base;
    checks++;
    if (n_got !== 5 + FFT_SIZE) begin
      failures++; $display("FAIL gap smp_count got=%0d exp=%0d", n_got, 5 + FFT_SIZE);
    end
    for (int i = 0; i < 5 + FFT_SIZE && i < n_got; i++) begin
      checks++;
      if (i < 5) begin
        if (smp_idx_q[s_base+i] !== IDX_W'(i) || smp_data_q[s_base+i] !== pre[i]) begin
          failures++;
          $display("FAIL gap partial[%0d] got idx=%0d data=%02h exp idx=%0d data=%02h", i,
                   smp_idx_q[s_base+i], smp_data_q[s_base+i], i, pre[i]);
        end
      end else begin
        if (smp_idx_q[s_base+i] !== IDX_W'(i - 5) || smp_data_q[s_base+i] !== frame[i-5]) begin
          failures++;
          $display("FAIL gap restart[%0d] got idx=%0d data=%02h exp idx=%0d data=%02h", i - 5,
                   smp_idx_q[s_base+i], smp_data_q[s_base+i], i - 5, frame[i-5]);
        end
      end
    end
    checks++;
    if (fft_start_n - f_base !== 1) begin
      failures++; $display("FAIL gap fft_start_count got=%0d exp=1", fft_start_n - f_base);
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    int t_base, e_base, f_base, c;
    t_base = tx_q.size();
    e_base = error_n;
    f_base = fft_start_n;
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    repeat (4) step();
    for (int i = 0; i < FFT_SIZE; i++) frame[i] = DATA_LENGTH'($urandom);
    send_frame(2, c);
    for (int k = 0; k < FFT_TIMEOUT + 50 && error_n == e_base; k++) step();
    repeat (3) step();
    checks++;
    if (error_n - e_base !== 1) begin
      failures++; $display("FAIL timeout error_count got=%0d exp=1", error_n - e_base);
    end
    checks++;
    if (error_cyc - fft_start_cyc !== FFT_TIMEOUT || fft_start_n - f_base !== 1) begin
      failures++;
      $display("FAIL timeout error_latency got=%0d exp=%0d starts=%0d", error_cyc - fft_start_cyc,
               FFT_TIMEOUT, fft_start_n - f_base);
    end
    checks++;
    if (tx_q.size() !== t_base || busy !== 1'b0) begin
      failures++; $display("FAIL timeout idle got tx=%0d busy=%b exp=0,0", tx_q.size() - t_base, busy);
    end
    for (int i = 0; i < FFT_SIZE; i++) fft_words[i] = WORD_SIZE'($urandom);
    frame_roundtrip("post_timeout", 2, 1'b0, -1);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < FFT_SIZE; i++) begin
      frame[i]     = DATA_LENGTH'($urandom);
      fft_words[i] = WORD_SIZE'($urandom);
    end
    frame_roundtrip("overrun", 1, 1'b0, 3);
  endtask

  task automatic test_reset_mid();
    int t_base, c, n_got;
    for (int i = 0; i < FFT_SIZE; i++) begin
      frame[i]     = DATA_LENGTH'($urandom);
      fft_words[i] = WORD_SIZE'($urandom);
    end
    t_base = tx_q.size();
    tx_frame_base = t_base;
    tx_stop_after = 7;
    send_frame(1, c);
    repeat (3) step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    for (int k = 0; k < 200 && tx_q.size() - t_base < 7; k++) step();
    repeat (8) step();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({smp_wr, smp_idx, smp_data, fft_start, rd_idx, tx_start, tx_byte, busy, overrun, error} !== '0) begin
      failures++;
      $display("FAIL reset_mid outputs got rd=%0d tb=%02h busy=%b exp=0", rd_idx, tx_byte, busy);
    end
    rst_n = 1'b1;
    repeat (20) step();
    n_got = tx_q.size() - t_base;
    checks++;
    if (n_got !== 7) begin
      failures++; $display("FAIL reset_mid tx_count got=%0d exp=7", n_got);
    end
    for (int j = 0; j < 7 && j < n_got; j++) begin
      checks++;
      if (tx_q[t_base+j] !== model_tx(j)) begin
        failures++; $display("FAIL reset_mid tx_byte[%0d] got=%02h exp=%02h", j, tx_q[t_base+j], model_tx(j));
      end
    end
    tx_stop_after = 1000000;
    for (int i = 0; i < FFT_SIZE; i++) begin
      frame[i]     = DATA_LENGTH'($urandom);
      fft_words[i] = WORD_SIZE'($urandom);
    end
    frame_roundtrip("after_reset", 1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FFT_SIZE; i++) begin
        frame[i]     = DATA_LENGTH'($urandom);
        fft_words[i] = WORD_SIZE'($urandom);
      end
      frame_roundtrip($sformatf("b2b%0d", f), 3, (f == 1), -1);
    end
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_byte  = '0;
    fft_done = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < FFT_SIZE; i++) fft_words[i] = '0;
    test_reset();
    test_collect_send();
    test_gap();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
